// File: rtl/xor_3_pkg.sv
// xor_3_pkg: shared constants for xor_3 (default counter width, register reset values)
package xor_3_pkg;
  localparam int   CNT_W_DEF = 8;
  localparam logic RES_Q_RST = 1'b0;
  localparam logic ACC_RST   = 1'b0;
endpackage

// File: rtl/xor_3_parity3.sv
// parity3: combinational 3-bit parity (par) and ones count (ones) of inputs a, b, c
module parity3 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       par,
  output logic [1:0] ones
);
  assign par  = a ^ b ^ c;
  assign ones = {1'b0, a} + {1'b0, b} + {1'b0, c};
endmodule

// File: rtl/xor_3.sv
// xor_3: 3-input XOR with registered copy, running XOR and odd-parity cycle counter; i_clk/i_rst(async), i_in0..2, i_en, i_clr -> o_res, o_ones, o_res_q, o_acc, o_odd_cnt
module xor_3
  import xor_3_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in0,
  input  logic             i_in1,
  input  logic             i_in2,
  input  logic             i_en,
  input  logic             i_clr,
  output logic             o_res,
  output logic [1:0]       o_ones,
  output logic             o_res_q,
  output logic             o_acc,
  output logic [CNT_W-1:0] o_odd_cnt
);
  parity3 u_par (
    .a   (i_in0),
    .b   (i_in1),
    .c   (i_in2),
    .par (o_res),
    .ones(o_ones)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_res_q   <= RES_Q_RST;
      o_acc     <= ACC_RST;
      o_odd_cnt <= '0;
    end else begin
      if (i_en) o_res_q <= o_res;
      if (i_clr) begin
        o_acc     <= 1'b0;
        o_odd_cnt <= '0;
      end else if (i_en) begin
        o_acc     <= o_acc ^ o_res;
        o_odd_cnt <= o_odd_cnt + CNT_W'(o_res);
      end
    end
endmodule

// File: tb/tb_xor_3.sv
// tb_xor_3: randomized and directed self-check of xor_3 (CNT_W=8 and CNT_W=2) against a counting model
module tb_xor_3;
  logic       clk, rst, in0, in1, in2, en, clr;
  logic       res, res_q, acc, res_b, res_q_b, acc_b;
  logic [1:0] ones, ones_b, cnt2;
  logic [7:0] cnt8;
  int total = 0, bad = 0;
  int unsigned n = 0;
  logic mq = 1'b0;
  logic [7:0] ptab = 8'h96;
  xor_3 dut (
    .i_clk(clk), .i_rst(rst), .i_in0(in0), .i_in1(in1), .i_in2(in2),
    .i_en(en), .i_clr(clr), .o_res(res), .o_ones(ones), .o_res_q(res_q),
    .o_acc(acc), .o_odd_cnt(cnt8)
  );
  xor_3 #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_in0(in0), .i_in1(in1), .i_in2(in2),
    .i_en(en), .i_clr(clr), .o_res(res_b), .o_ones(ones_b), .o_res_q(res_q_b),
    .o_acc(acc_b), .o_odd_cnt(cnt2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all(input string tag);
    int k;
    k = $countones({in2, in1, in0});
    chk({tag, " res"}, 32'(res), 32'(k % 2));
    chk({tag, " ones"}, 32'(ones), 32'(k));
    chk({tag, " res_q"}, 32'(res_q), 32'(mq));
    chk({tag, " acc"}, 32'(acc), 32'(n % 2));
    chk({tag, " cnt8"}, 32'(cnt8), n % 256);
    chk({tag, " cnt2"}, 32'(cnt2), n % 4);
  endtask
  task automatic cyc(input logic [2:0] b, input logic e, input logic c, input string tag);
    int p;
    {in2, in1, in0} = b;
    en = e;
    clr = c;
    p = $countones(b) % 2;
    @(posedge clk);
    if (rst) begin
      mq = 1'b0;
      n = 0;
    end else begin
      if (e) mq = p[0];
      if (c) n = 0;
      else if (e && p == 1) n++;
    end
    @(negedge clk);
    check_all(tag);
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; {in2, in1, in0} = 3'b000;
    #2;
    check_all("reset");
    for (int i = 0; i < 8; i++) begin
      {in2, in1, in0} = 3'(i);
      #10;
      chk("tab res", 32'(res), 32'(ptab[i]));
      chk("tab ones", 32'(ones), 32'($countones(3'(i))));
      chk("tab ones_b", 32'(ones_b), 32'($countones(3'(i))));
    end
    @(negedge clk);
    cyc(3'b111, 1'b1, 1'b0, "rst hold en");
    cyc(3'b001, 1'b1, 1'b1, "rst hold clr");
    rst = 1'b0;
    cyc(3'b001, 1'b1, 1'b0, "seq001");
    chk("seq001 acc", 32'(acc), 32'd1);
    chk("seq001 cnt", 32'(cnt8), 32'd1);
    cyc(3'b011, 1'b1, 1'b0, "seq011");
    chk("seq011 res_q", 32'(res_q), 32'd0);
    cyc(3'b111, 1'b1, 1'b0, "seq111");
    chk("seq111 acc", 32'(acc), 32'd0);
    cyc(3'b100, 1'b1, 1'b0, "seq100");
    chk("seq100 cnt", 32'(cnt8), 32'd3);
    cyc(3'b111, 1'b1, 1'b1, "clr");
    chk("clr res_q", 32'(res_q), 32'd1);
    chk("clr cnt", 32'(cnt8), 32'd0);
    for (int i = 0; i < 5; i++) cyc(3'b001, 1'b1, 1'b0, "wrap");
    chk("wrap cnt2", 32'(cnt2), 32'd1);
    chk("wrap cnt8", 32'(cnt8), 32'd5);
    cyc(3'b110, 1'b0, 1'b0, "hold a");
    cyc(3'b111, 1'b0, 1'b0, "hold b");
    cyc(3'b010, 1'b0, 1'b0, "hold c");
    chk("hold cnt", 32'(cnt8), 32'd5);
    cyc(3'b000, 1'b1, 1'b1, "pre clr");
    cyc(3'b100, 1'b1, 1'b0, "pre a");
    cyc(3'b111, 1'b1, 1'b0, "pre b");
    chk("pre cnt", 32'(cnt8), 32'd2);
    #2;
    rst = 1'b1;
    {in2, in1, in0} = 3'b011;
    #1;
    chk("async res_q", 32'(res_q), 32'd0);
    chk("async acc", 32'(acc), 32'd0);
    chk("async cnt", 32'(cnt8), 32'd0);
    chk("async res", 32'(res), 32'd0);
    {in2, in1, in0} = 3'b010;
    #1;
    chk("async res2", 32'(res), 32'd1);
    mq = 1'b0;
    n = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++)
      cyc(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, "rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
